bf_p_key_mixer: RTL

Key-mixing stage that sits directly downstream of the Blowfish P-array constant ROM. It sequences the 5-bit ROM index through entries 0..17 and XORs each 32-bit constant with the cyclically repeated user key. The 18 mixed subkeys are stored in an internal register file for the Feistel round engine. A write port lets the later key-expansion pass overwrite entries with encryption outputs.

---
 rtl/bf_p_key_mixer_if.sv | 36 +++
 rtl/bf_p_key_mixer.sv | 106 ++++++++++
 2 files changed

// File: rtl/bf_p_key_mixer_if.sv
// Bus bundle for the Blowfish P-array key mixer: ROM index/data, start/status, write and read ports.
// BF_KEYLEN_CHECK_EN adds the err status line.
interface bf_p_key_mixer_if;
  logic         start;
  logic [447:0] key;
  logic [3:0]   key_len;
  logic [4:0]   p_idx;
  logic [31:0]  p_rom;
  logic         busy;
  logic         done;
  logic         p_valid;
  logic         wr_en;
  logic [4:0]   wr_idx;
  logic [31:0]  wr_data;
  logic [4:0]   rd_idx;
  logic [31:0]  rd_data;
`ifdef BF_KEYLEN_CHECK_EN
  logic         err;
`endif

  modport master (
    output start, key, key_len, p_rom, wr_en, wr_idx, wr_data, rd_idx,
    input  p_idx, busy, done, p_valid, rd_data
`ifdef BF_KEYLEN_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  start, key, key_len, p_rom, wr_en, wr_idx, wr_data, rd_idx,
    output p_idx, busy, done, p_valid, rd_data
`ifdef BF_KEYLEN_CHECK_EN
    , output err
`endif
  );
endinterface

// File: rtl/bf_p_key_mixer.sv
// Blowfish P-array key mixer: XORs ROM constants 0..17 with the cyclic user key into a subkey file.
// Optional BF_KEYLEN_CHECK_EN rejects illegal key_len with a one-cycle err pulse instead of clamping.
module bf_p_key_mixer #(
  parameter int unsigned NUM_P         = 18,
  parameter int unsigned MAX_KEY_WORDS = 14
) (
  input logic             clk,
  input logic             rst,
  bf_p_key_mixer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMix, StDone} state_e;

  localparam logic [4:0] LastIdx = 5'(NUM_P - 1);

  state_e       state_q, state_d;
  logic [4:0]   idx_q;
  logic [3:0]   k_q;
  logic [3:0]   len_q;
  logic [447:0] key_q;
  logic         p_valid_q;
  logic [31:0]  rd_data_q;
  logic [31:0]  p_mem [NUM_P];

  logic         key_len_bad;
  logic [3:0]   len_eff;
  logic         start_ok;
  logic [447:0] key_sh;
  logic [31:0]  mix_data;

  assign key_len_bad = (bus.key_len == 4'd0) || (32'(bus.key_len) > MAX_KEY_WORDS);
  assign len_eff     = key_len_bad ? 4'(MAX_KEY_WORDS) : bus.key_len;

`ifdef BF_KEYLEN_CHECK_EN
  assign start_ok = (state_q == StIdle) && bus.start && !key_len_bad;
`else
  assign start_ok = (state_q == StIdle) && bus.start;
`endif

  // Word k sits at key_q[447-32k -: 32]; shift it up to the top slot.
  assign key_sh   = key_q << (32 * k_q);
  assign mix_data = bus.p_rom ^ key_sh[447:416];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_ok) state_d = StMix;
      StMix:   if (idx_q == LastIdx) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      k_q       <= '0;
      len_q     <= '0;
      key_q     <= '0;
      p_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= (bus.rd_idx <= LastIdx) ? p_mem[bus.rd_idx] : '0;
      if (start_ok) begin
        key_q     <= bus.key;
        len_q     <= len_eff;
        idx_q     <= '0;
        k_q       <= '0;
        p_valid_q <= 1'b0;
      end else if (state_q == StMix) begin
        k_q <= (k_q == len_q - 4'd1) ? 4'd0 : k_q + 4'd1;
        if (idx_q != LastIdx) idx_q <= idx_q + 5'd1;
        else                  p_valid_q <= 1'b1;
      end
    end
  end

  // Mixing owns the register file during MIX; the external write port is honoured otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_P); i++) p_mem[i] <= '0;
    end else if (state_q == StMix) begin
      p_mem[idx_q] <= mix_data;
    end else if (bus.wr_en && (bus.wr_idx <= LastIdx)) begin
      p_mem[bus.wr_idx] <= bus.wr_data;
    end
  end

`ifdef BF_KEYLEN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_q == StIdle) && bus.start && key_len_bad;
  end
  assign bus.err = err_q;
`endif

  assign bus.p_idx   = idx_q;
  assign bus.busy    = (state_q == StMix);
  assign bus.done    = (state_q == StDone);
  assign bus.p_valid = p_valid_q;
  assign bus.rd_data = rd_data_q;

endmodule
